sipo_word_loader: RTL
=====================

Name: sipo_word_loader

Overview:
- Serial-in, parallel-out front end that sits directly upstream of the 4-bit PIPO register.
- Collects bits from a serial valid/ready stream into a WIDTH-bit word.
- Presents the word on data_o and pulses load_o for one cycle so the PIPO captures it on the next edge.
- Supports downstream stall (hold_i), synchronous abort (clear_i) and back-to-back words.

Parameters:
- WIDTH, 4: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in data_o[WIDTH-1]; 0 = first bit lands in data_o[0].

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  reset.
- ser_valid_i  in  1  serial bit valid.
- ser_data_i  in  1  serial bit.
- ser_ready_o  out  1  block accepts a bit this cycle.
- hold_i  in  1  downstream stall; suppresses load_o.
- clear_i  in  1  synchronous abort of the partial or pending word.
- data_o  out  WIDTH  assembled word, stable between completions.
- load_o  out  1  one-cycle load strobe to the PIPO.
- busy_o  out  1  partial word in progress or word pending.
- parity_err_o  out  1  one-cycle parity-failure pulse (see Optional Feature).

Interface: one clock; reset is asynchronous and active-low (clk_i, rst_n_i).

Behaviour:
- Beat: a bit is transferred in any cycle where ser_valid_i and ser_ready_o are both 1.
- Reset (rst_n_i low, asynchronous):
  - state = COLLECT, bit count = 0, shift register = 0.
  - data_o = 0, load_o = 0, parity_err_o = 0, busy_o = 0.
  - No beat is accepted while rst_n_i is low.
- COLLECT state:
  - ser_ready_o = 1 (unless clear_i is 1).
  - Each beat shifts ser_data_i into the internal shift register and increments the count.
  - Beat with count = FRAME-1: the word is copied into data_o at that edge, count returns to 0, and the state moves to FULL.
  - FRAME = WIDTH, or WIDTH+1 when the parity feature is compiled in.
- FULL state:
  - load_o = ~hold_i & ~clear_i.
  - ser_ready_o = ~hold_i & ~clear_i.
  - When load_o = 1, the next state is COLLECT. A beat accepted in the same cycle is bit 0 of the next word (zero-bubble back-to-back).
  - When hold_i = 1, the block stays in FULL with data_o unchanged and no beats accepted, for any number of cycles.
- Latency:
  - Last beat at edge N: data_o is valid after N, and load_o is high in cycle N+1 if hold_i = 0.
  - The PIPO captures data_o at edge N+2.
  - Sustained throughput is one word per FRAME cycles.
- clear_i (highest priority below reset):
  - Forces ser_ready_o = 0 and load_o = 0 that cycle.
  - Next state is COLLECT with count = 0; the partial word is discarded.
  - A pending FULL word is dropped (never loaded); data_o is unchanged.
- busy_o = (count != 0) | (state == FULL).
- load_o and parity_err_o are never asserted in the same cycle.
- hold_i has no effect in COLLECT.
- Reset mid-word or mid-FULL: all state is cleared immediately; no load_o is issued for the in-flight word.

Optional Feature:
- Macro: SIPO_WORD_LOADER_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit. The expected parity bit equals the XOR of the data bits.
  - On the parity beat, if the parity matches: data_o updates, state → FULL.
  - On mismatch: data_o unchanged, state stays COLLECT, count = 0, parity_err_o = 1 in the following cycle, no load_o.
- Undefined:
  - Frame = WIDTH bits and no parity logic is present.
  - parity_err_o is tied to 0.

Decomposition:
- Package sipo_word_loader_pkg holds:
  - state enum { COLLECT, FULL };
  - function cnt_w(WIDTH) returning $clog2(WIDTH+2);
  - the localparam for the parity frame extension.
- No sub-module; a single module is natural.

Test Plan (WIDTH=4 unless noted):
1. MSB_FIRST=1; beats 1,0,1,1 in consecutive cycles, hold_i=0 → data_o=4'hB after 4th beat; load_o=1 exactly one cycle later; busy_o low after load.
2. MSB_FIRST=0; same beats 1,0,1,1 → data_o=4'hD; single load_o pulse.
3. Stall and back-to-back:
   - Word 4'hB completes with hold_i=1 for 3 cycles, with ser_valid_i=1 throughout → load_o=0 and ser_ready_o=0 for 3 cycles, data_o holds 4'hB.
   - Release hold_i → load_o=1 and a beat accepted in that same cycle.
   - Following beats 0,1,1,0 → data_o=4'h6.
4. Clear and reset mid-word:
   - Beats 1,1, then clear_i=1 for one cycle, then 1,1,0,0 → data_o=4'hC; only one load_o.
   - Separately, deassert rst_n_i after 2 beats → data_o=0 and no load_o; the next 4 beats form a fresh word.
5. SIPO_WORD_LOADER_PARITY_EN defined:
   - Frame 1,0,1,1 followed by parity bit 1 → data_o=4'hB, load_o pulse.
   - Frame 0,1,1,1 followed by parity bit 0 → parity_err_o pulse, data_o stays 4'hB, no load_o.

Source files
------------

// File: rtl/sipo_word_loader_pkg.sv
// Shared types and sizing helpers for sipo_word_loader.
// SIPO_WORD_LOADER_PARITY_EN adds one even-parity bit to every serial frame.
package sipo_word_loader_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  // Bit counter must reach WIDTH (the parity beat), so size for WIDTH+2 values.
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

`ifdef SIPO_WORD_LOADER_PARITY_EN
  localparam int PAR_EXT = 1;
`else
  localparam int PAR_EXT = 0;
`endif

endpackage

// File: rtl/sipo_word_loader.sv
// Serial valid/ready bit stream to WIDTH-bit word, with a one-cycle load strobe for a PIPO.
// Define SIPO_WORD_LOADER_PARITY_EN to append an even-parity bit to each frame.
module sipo_word_loader
  import sipo_word_loader_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             ser_valid_i,
  input  logic             ser_data_i,
  output logic             ser_ready_o,
  input  logic             hold_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] data_o,
  output logic             load_o,
  output logic             busy_o,
  output logic             parity_err_o
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam int            FRAME    = WIDTH + PAR_EXT;
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("sipo_word_loader: WIDTH must be in 2..32");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] sr_shift;
  logic             ready;
  logic             load;
  logic             beat;

`ifdef SIPO_WORD_LOADER_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
`ifdef SIPO_WORD_LOADER_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
`ifdef SIPO_WORD_LOADER_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Incoming bit enters at the LSB end for MSB-first, at the MSB end otherwise.
  always_comb begin
    if (MSB_FIRST != 0) begin
      sr_shift = {sr_q[WIDTH-2:0], ser_data_i};
    end else begin
      sr_shift = {ser_data_i, sr_q[WIDTH-1:1]};
    end
  end

  assign beat = ser_valid_i & ready;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    data_d  = data_q;
`ifdef SIPO_WORD_LOADER_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (clear_i) begin
      state_d = COLLECT;
      cnt_d   = '0;
`ifdef SIPO_WORD_LOADER_PARITY_EN
      par_d   = 1'b0;
`endif
    end else begin
      if (load) begin
        state_d = COLLECT;
      end
      // A beat in the load cycle is bit 0 of the next word; count is already 0 in FULL.
      if (beat) begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
`ifdef SIPO_WORD_LOADER_PARITY_EN
          par_d = 1'b0;
          if (ser_data_i == par_q) begin
            data_d  = sr_q;
            state_d = FULL;
          end else begin
            perr_d  = 1'b1;
          end
`else
          sr_d    = sr_shift;
          data_d  = sr_shift;
          state_d = FULL;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
          sr_d  = sr_shift;
`ifdef SIPO_WORD_LOADER_PARITY_EN
          par_d = par_q ^ ser_data_i;
`endif
        end
      end
    end
  end

  // Output logic; ready is gated by reset so nothing is taken while rst_n_i is low.
  always_comb begin
    ready = 1'b0;
    load  = 1'b0;
    if (rst_n_i && !clear_i) begin
      if (state_q == COLLECT) begin
        ready = 1'b1;
      end else begin
        ready = ~hold_i;
        load  = ~hold_i;
      end
    end
  end

  assign ser_ready_o = ready;
  assign load_o      = load;
  assign data_o      = data_q;
  assign busy_o      = (cnt_q != '0) | (state_q == FULL);

`ifdef SIPO_WORD_LOADER_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
